// File: rtl/avalon_host_master_if.sv
// Avalon-MM bus bundle between the host master and the accelerator slave.
// master: drives address/read/write/writedata/beginbursttransfer/burstcount;
// slave: drives waitrequest/readdata/readdatavalid/response/writeresponsevalid.
interface avalon_host_master_if #(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 10
);
   logic [ADDR_W-1:0]  address;
   logic               read;
   logic               write;
   logic [DATA_W-1:0]  writedata;
   logic               beginbursttransfer;
   logic [BURST_W-1:0] burstcount;
   logic               waitrequest;
   logic [DATA_W-1:0]  readdata;
   logic               readdatavalid;
   logic [1:0]         response;
   logic               writeresponsevalid;

   modport master (
      output address, read, write, writedata,
      output beginbursttransfer, burstcount,
      input  waitrequest, readdata, readdatavalid,
      input  response, writeresponsevalid
   );

   modport slave (
      input  address, read, write, writedata,
      input  beginbursttransfer, burstcount,
      output waitrequest, readdata, readdatavalid,
      output response, writeresponsevalid
   );
endinterface

// File: rtl/avalon_host_master.sv
// Avalon-MM initiator: turns WRITE/READ/BURST_WR/POLL commands into bus cycles.
// Ports: clk/rst, cmd_* command port, wd_* burst word stream,
// done/done_code/rdata completion, av = Avalon master bundle.
module avalon_host_master #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int BURST_W    = 10,
   parameter int POLL_LIMIT = 1024,
   parameter int RD_TIMEOUT = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [BURST_W-1:0] cmd_len,
   input  logic [DATA_W-1:0]  cmd_data,
   input  logic               wd_valid,
   output logic               wd_ready,
   input  logic [DATA_W-1:0]  wd_data,
   output logic               done,
   output logic [1:0]         done_code,
   output logic [DATA_W-1:0]  rdata,
   avalon_host_master_if.master av
);
   localparam int TW = $clog2(RD_TIMEOUT + 1);
   localparam int PW = $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE, WR, RD_REQ, RD_WAIT, BURST, POLL_REQ, POLL_WAIT, FIN
   } state_t;

   state_t             state;
   logic [DATA_W-1:0]  mask;
   logic [BURST_W-1:0] len;
   logic [BURST_W-1:0] beats;
   logic [TW-1:0]      tmr;
   logic [PW-1:0]      polls;
   logic               wr_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         cmd_ready             <= 1'b1;
         wd_ready              <= 1'b0;
         done                  <= 1'b0;
         done_code             <= 2'b00;
         rdata                 <= '0;
         av.address            <= '0;
         av.read               <= 1'b0;
         av.write              <= 1'b0;
         av.writedata          <= '0;
         av.beginbursttransfer <= 1'b0;
         av.burstcount         <= '0;
         mask                  <= '0;
         len                   <= '0;
         beats                 <= '0;
         tmr                   <= '0;
         polls                 <= '0;
         wr_acc                <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready  <= 1'b0;
                  av.address <= cmd_addr;
                  mask       <= cmd_data;
                  len        <= cmd_len;
                  beats      <= '0;
                  tmr        <= '0;
                  polls      <= '0;
                  wr_acc     <= 1'b0;
                  done_code  <= 2'b00;
                  unique case (cmd_op)
                     2'b00: begin
                        state        <= WR;
                        av.write     <= 1'b1;
                        av.writedata <= cmd_data;
                     end
                     2'b01: begin
                        state   <= RD_REQ;
                        av.read <= 1'b1;
                     end
                     2'b10: begin
                        if (cmd_len == '0) begin
                           state     <= FIN;
                           done      <= 1'b1;
                           done_code <= 2'b11;
                        end else begin
                           state         <= BURST;
                           wd_ready      <= 1'b1;
                           av.burstcount <= cmd_len;
                        end
                     end
                     2'b11: begin
                        state   <= POLL_REQ;
                        av.read <= 1'b1;
                     end
                  endcase
               end
            end

            // Second phase waits one cycle for an optional write response.
            WR: begin
               if (!wr_acc) begin
                  if (!av.waitrequest) begin
                     av.write <= 1'b0;
                     wr_acc   <= 1'b1;
                  end
               end else begin
                  if (av.writeresponsevalid && av.response != 2'b00)
                     done_code <= 2'b01;
                  state <= FIN;
                  done  <= 1'b1;
               end
            end

            RD_REQ, POLL_REQ: begin
               if (!av.waitrequest) begin
                  av.read <= 1'b0;
                  tmr     <= '0;
                  if (state == POLL_REQ) begin
                     polls <= polls + PW'(1);
                     state <= POLL_WAIT;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end

            RD_WAIT, POLL_WAIT: begin
               if (av.readdatavalid) begin
                  rdata <= av.readdata;
                  if (av.response != 2'b00) begin
                     state     <= FIN;
                     done      <= 1'b1;
                     done_code <= 2'b01;
                  end else if (state == RD_WAIT ||
                               (av.readdata & mask) != '0) begin
                     state     <= FIN;
                     done      <= 1'b1;
                     done_code <= 2'b00;
                  end else if (polls == PW'(POLL_LIMIT)) begin
                     state     <= FIN;
                     done      <= 1'b1;
                     done_code <= 2'b10;
                  end else begin
                     state   <= POLL_REQ;
                     av.read <= 1'b1;
                  end
               end else if (tmr == TW'(RD_TIMEOUT - 1)) begin
                  state     <= FIN;
                  done      <= 1'b1;
                  done_code <= 2'b10;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end

            // One word held at a time: wd_ready is high exactly while
            // writedata is empty, so a load never collides with a beat.
            BURST: begin
               if (av.write) begin
                  if (!av.waitrequest) begin
                     av.write              <= 1'b0;
                     av.beginbursttransfer <= 1'b0;
                     av.burstcount         <= '0;
                     av.address            <= '0;
                     beats                 <= beats + BURST_W'(1);
                     if (beats == len - BURST_W'(1)) begin
                        state     <= FIN;
                        done      <= 1'b1;
                        done_code <= 2'b00;
                     end else begin
                        wd_ready <= 1'b1;
                     end
                  end
               end else if (wd_ready && wd_valid) begin
                  wd_ready     <= 1'b0;
                  av.write     <= 1'b1;
                  av.writedata <= wd_data;
                  if (beats == '0)
                     av.beginbursttransfer <= 1'b1;
               end
            end

            FIN: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
